// File: rtl/m_pkg.sv
// Shared opcode/func definitions for the M and custom modular-arithmetic coprocessor.
package m_pkg;

  localparam logic [6:0] OPCODE        = 7'b0110011;
  localparam logic [6:0] FUNC7         = 7'b0000001;
  localparam logic [6:0] OPCODE_CUSTOM = 7'b0001011;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } mul_func3_e;

  // func3 space under OPCODE_CUSTOM
  typedef enum logic [2:0] {
    ADDMOD = 3'b000,
    SUBMOD = 3'b001,
    MODQ   = 3'b010
  } func3_e;

  function automatic logic [6:0] get_ir_opcode(logic [31:0] ir);
    return ir[6:0];
  endfunction

  function automatic logic [4:0] get_ir_rd(logic [31:0] ir);
    return ir[11:7];
  endfunction

  function automatic logic [2:0] get_ir_func3(logic [31:0] ir);
    return ir[14:12];
  endfunction

  function automatic logic [4:0] get_ir_rs1(logic [31:0] ir);
    return ir[19:15];
  endfunction

  function automatic logic [4:0] get_ir_rs2(logic [31:0] ir);
    return ir[24:20];
  endfunction

  function automatic logic [6:0] get_ir_func7(logic [31:0] ir);
    return ir[31:25];
  endfunction

  function automatic logic is_coproc_insn(logic [31:0] ir);
    logic m_hit;
    logic c_hit;
    m_hit = (get_ir_opcode(ir) == OPCODE) && (get_ir_func7(ir) == FUNC7);
    c_hit = (get_ir_opcode(ir) == OPCODE_CUSTOM) &&
            ((get_ir_func3(ir) == ADDMOD) || (get_ir_func3(ir) == SUBMOD) ||
             (get_ir_func3(ir) == MODQ));
    return m_hit || c_hit;
  endfunction

endpackage

// File: rtl/m_pcpi_frontend.sv
// Registered PCPI front-end: claims coprocessor instructions, holds operands,
// returns a registered result, and recovers from hung or abandoned operations.
module m_pcpi_frontend
  import m_pkg::*;
#(
  parameter int TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_insn,
  input  logic [31:0] cpu_rs1,
  input  logic [31:0] cpu_rs2,
  output logic        cpu_wr,
  output logic [31:0] cpu_rd,
  output logic        cpu_wait,
  output logic        cpu_ready,
  output logic        core_valid,
  output logic [31:0] core_insn,
  output logic [31:0] core_rs1,
  output logic [31:0] core_rs2,
  input  logic        core_wr,
  input  logic [31:0] core_rd,
  input  logic        core_busy,
  input  logic        core_ready,
  output logic        err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN, COOL} state_e;

  state_e        state, state_nxt;
  logic [TW-1:0] timer;
  logic [31:0]   rd_q;
  logic          wr_q;
  logic          accept;
  logic          timer_hit;
  logic          unused;

  // busy is informational only; the handshake relies solely on core_ready
  assign unused = core_busy;

  assign accept    = cpu_valid && is_coproc_insn(cpu_insn);
  assign timer_hit = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (core_ready || timer_hit) state_nxt = RESP;
        else if (!cpu_valid)         state_nxt = DRAIN;
      end
      RESP:    state_nxt = COOL;
      DRAIN:   if (core_ready || timer_hit) state_nxt = COOL;
      COOL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      rd_q        <= '0;
      wr_q        <= 1'b0;
      core_insn   <= '0;
      core_rs1    <= '0;
      core_rs2    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;

      // timer reads 0 during ISSUE so the forced RESP lands at cycle TIMEOUT+1
      if (state == IDLE && accept) begin
        core_insn <= cpu_insn;
        core_rs1  <= cpu_rs1;
        core_rs2  <= cpu_rs2;
        timer     <= '0;
      end else if ((state == ISSUE || state == WAIT || state == DRAIN) &&
                   timer != {TW{1'b1}}) begin
        timer <= timer + 1'b1;
      end

      if (state == WAIT) begin
        if (core_ready) begin
          rd_q <= core_rd;
          wr_q <= core_wr;
        end else if (timer_hit) begin
          rd_q        <= '0;
          wr_q        <= 1'b0;
          err_timeout <= 1'b1;
        end
      end

      if (state == DRAIN && !core_ready && timer_hit) err_timeout <= 1'b1;
    end
  end

  assign core_valid = (state == ISSUE);
  assign cpu_wait   = (state == ISSUE) || (state == WAIT);
  assign cpu_ready  = (state == RESP);
  assign cpu_rd     = cpu_ready ? rd_q : '0;
  assign cpu_wr     = cpu_ready && wr_q;

endmodule

// File: tb/tb_m_pcpi_frontend.sv
// Directed bench for m_pcpi_frontend: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever cpu_ready is presented.
module tb_m_pcpi_frontend;
  import m_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [31:0] cpu_insn = '0;
  logic [31:0] cpu_rs1 = '0;
  logic [31:0] cpu_rs2 = '0;
  logic        cpu_wr;
  logic [31:0] cpu_rd;
  logic        cpu_wait;
  logic        cpu_ready;
  logic        core_valid;
  logic [31:0] core_insn;
  logic [31:0] core_rs1;
  logic [31:0] core_rs2;
  logic        core_wr = 1'b1;
  logic [31:0] core_res = '0;
  logic        core_busy;
  logic        core_ready = 1'b0;
  logic        err_timeout;

  m_pcpi_frontend #(.TIMEOUT(48)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_insn(cpu_insn), .cpu_rs1(cpu_rs1), .cpu_rs2(cpu_rs2),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_wait(cpu_wait), .cpu_ready(cpu_ready),
    .core_valid(core_valid), .core_insn(core_insn), .core_rs1(core_rs1), .core_rs2(core_rs2),
    .core_wr(core_wr), .core_rd(core_res), .core_busy(core_busy), .core_ready(core_ready),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] rd;
    logic        wr;
    int          at;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic [6:0] f7, logic [2:0] f3, logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  // coprocessor model: core_ready pulses core_lat cycles after core_valid (0 = never)
  int core_lat = 0;
  int cd = 0;
  assign core_busy = (cd > 0);
  always @(negedge clk) begin
    core_ready = 1'b0;
    if (reset) cd = 0;
    else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) core_ready = 1'b1;
      end
      if (core_valid && core_lat > 0) cd = core_lat;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (cpu_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready cyc=%0d rd=%h wr=%0b", cyc, cpu_rd, cpu_wr);
        end else begin
          e = q.pop_front();
          chk("resp_rd", cpu_rd, e.rd);
          chk("resp_wr", {31'd0, cpu_wr}, {31'd0, e.wr});
          chk("resp_cycle", cyc, e.at);
        end
      end else begin
        chk("rd_zero_idle", cpu_rd, 32'd0);
      end
    end
  end

  // drives one request from the current negedge (cycle 0) and checks handshake per cycle
  task automatic run_op(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int acc, input int wait_last, input int resp, input int ncyc,
                        input int drop, input logic hit, input logic [31:0] exp_rd,
                        input logic exp_wr);
    int base;
    base = cyc;
    cpu_valid = 1'b1;
    cpu_insn  = insn;
    cpu_rs1   = rs1;
    cpu_rs2   = rs2;
    if (resp > 0) q.push_back('{exp_rd, exp_wr, base + resp});
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      chk("core_valid", {31'd0, core_valid}, {31'd0, (hit && c == acc + 1)});
      chk("cpu_wait", {31'd0, cpu_wait}, {31'd0, (hit && c > acc && c <= wait_last)});
      if (hit && c > acc) begin
        chk("core_insn_hold", core_insn, insn);
        chk("core_rs1_hold", core_rs1, rs1);
        chk("core_rs2_hold", core_rs2, rs2);
      end
      if (cpu_ready || c == drop) cpu_valid = 1'b0;
    end
    if (resp == 0 && drop == 0) cpu_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_core_valid", {31'd0, core_valid}, 32'd0);
    chk("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_cpu_rd", cpu_rd, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_core_insn", core_insn, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MUL 7*6, core_ready at cycle 3 -> cpu_ready at cycle 4
    core_lat = 2; core_res = 32'd42;
    run_op(mk(FUNC7, F3_MUL, OPCODE), 32'd7, 32'd6, 0, 3, 4, 6, 0, 1'b1, 32'd42, 1'b1);

    // DIVU 5/0, core_ready at cycle 35 -> cpu_ready at cycle 36
    core_lat = 34; core_res = 32'hFFFF_FFFF;
    run_op(mk(FUNC7, F3_DIVU, OPCODE), 32'd5, 32'd0, 0, 35, 36, 38, 0, 1'b1, 32'hFFFF_FFFF, 1'b1);

    // custom ADDMOD, core_ready at cycle 2
    core_lat = 1; core_res = 32'd30;
    run_op(mk(7'd0, ADDMOD, OPCODE_CUSTOM), 32'd10, 32'd20, 0, 2, 3, 5, 0, 1'b1, 32'd30, 1'b1);

    // plain ADD and an unclaimed custom func3 are ignored
    run_op(mk(7'd0, F3_MUL, OPCODE), 32'd1, 32'd2, 0, 0, 0, 20, 0, 1'b0, 32'd0, 1'b0);
    run_op(mk(7'd0, 3'b111, OPCODE_CUSTOM), 32'd1, 32'd2, 0, 0, 0, 5, 0, 1'b0, 32'd0, 1'b0);

    // stalled core: forced completion at cycle 49 with zero result
    chk("err_before_timeout", {31'd0, err_timeout}, 32'd0);
    core_lat = 0;
    run_op(mk(FUNC7, F3_MUL, OPCODE), 32'd4, 32'd4, 0, 48, 49, 51, 0, 1'b1, 32'd0, 1'b0);
    chk("err_after_timeout", {31'd0, err_timeout}, 32'd1);

    // abort at cycle 10 of a DIV; core_ready at 35 drains, COOL at 36
    core_lat = 34; core_res = 32'h0000_1234;
    run_op(mk(FUNC7, F3_DIV, OPCODE), 32'd100, 32'd7, 0, 10, 0, 36, 10, 1'b1, 32'd0, 1'b0);
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);
    // request raised in COOL is only accepted in the following IDLE cycle
    core_lat = 2; core_res = 32'd18;
    run_op(mk(FUNC7, F3_MUL, OPCODE), 32'd2, 32'd9, 1, 4, 5, 7, 0, 1'b1, 32'd18, 1'b1);

    // reset in the middle of WAIT
    core_lat = 0;
    cpu_valid = 1'b1; cpu_insn = mk(FUNC7, F3_MULHU, OPCODE); cpu_rs1 = 32'd11; cpu_rs2 = 32'd12;
    repeat (10) @(negedge clk);
    chk("pre_reset_wait", {31'd0, cpu_wait}, 32'd1);
    reset = 1'b1;
    cpu_valid = 1'b0;
    #1;
    chk("arst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    chk("arst_core_valid", {31'd0, core_valid}, 32'd0);
    chk("arst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("arst_cpu_wr", {31'd0, cpu_wr}, 32'd0);
    chk("arst_err", {31'd0, err_timeout}, 32'd0);
    chk("arst_core_rs1", core_rs1, 32'd0);
    chk("arst_core_insn", core_insn, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    core_lat = 2; core_res = 32'hFFFF_FFFD;
    run_op(mk(FUNC7, F3_MUL, OPCODE), 32'd3, 32'hFFFF_FFFF, 0, 3, 4, 6, 0, 1'b1,
           32'hFFFF_FFFD, 1'b1);

    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_pcpi_frontend.md
# m_pcpi_frontend

Registered PCPI front-end between the PicoRV32 core's PCPI port and the M/custom-arithmetic coprocessor, i.e. the multiply/divide/modular controller plus its datapath.
- Claims only instructions the coprocessor implements and latches instruction and operands so they stay stable until the coprocessor's final (DONE) cycle.
- Registers the result and returns it to the CPU with a one-cycle ready pulse.
- Adds a timeout watchdog and a clean abort/drain path, so a hung or abandoned operation never deadlocks the CPU.

## Interface
- TIMEOUT, 48: max cycles in WAIT before forced completion; legal range 40..255 (a worst-case DIV needs 35).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_valid  in  1  PCPI request from CPU.
- cpu_insn  in  32  instruction word.
- cpu_rs1, cpu_rs2  in  32  operands.
- cpu_wr  out  1  result valid for rd, qualified by cpu_ready.
- cpu_rd  out  32  result.
- cpu_wait  out  1  stall request to CPU.
- cpu_ready  out  1  completion pulse.
- core_valid  out  1  request pulse to coprocessor.
- core_insn  out  32  latched instruction.
- core_rs1, core_rs2  out  32  latched operands.
- core_wr  in  1  coprocessor result-valid.
- core_rd  in  32  coprocessor result.
- core_busy  in  1  coprocessor busy (observed only; no control effect).
- core_ready  in  1  coprocessor completion pulse.
- err_timeout  out  1  sticky flag, set on any timeout; cleared only by reset.

## Operation
- Decode hit requires either:
  - opcode == OPCODE and func7 == FUNC7 (any func3), or
  - opcode == OPCODE_CUSTOM and func3 is one of ADDMOD, SUBMOD, MODQ.
- Anything else is ignored: no wait, no ready; the CPU's own PCPI timeout traps it.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN, COOL.
- IDLE:
  - cpu_valid and decode hit: latch cpu_insn/rs1/rs2 into the core_* registers, go to ISSUE.
  - Otherwise stay.
- ISSUE:
  - core_valid=1 for exactly one cycle; cpu_wait=1; clear the timer.
  - Go to WAIT.
- WAIT:
  - cpu_wait=1; timer increments each cycle.
  - core_ready: capture cpu_rd<=core_rd and cpu_wr<=core_wr, go to RESP.
  - Else timer == TIMEOUT-1: cpu_rd<=0, cpu_wr<=0, set err_timeout, go to RESP.
  - Else cpu_valid low (abort): go to DRAIN.
- RESP:
  - cpu_ready=1 for one cycle, with cpu_wr/cpu_rd as captured; cpu_wait=0.
  - Go to COOL.
- DRAIN:
  - cpu_wait=0; no cpu_ready.
  - Leave for COOL on core_ready (result discarded) or on timeout (sets err_timeout).
- COOL:
  - One cycle; cpu_valid is ignored because the CPU is still deasserting it.
  - Go to IDLE.
- core_insn/core_rs1/core_rs2 hold their values from the latch until the next acceptance; they never change while in ISSUE, WAIT or DRAIN.
- Priority in WAIT: core_ready > timeout > abort.
  - core_ready coinciding with a cpu_valid drop still goes to RESP.
- cpu_rd is zero whenever cpu_ready=0.

## Timing
- Reset value of every output is 0; state goes to IDLE and the timer to 0. Reset may arrive in any state; the next cycle after release is IDLE.
- Request sampled in IDLE at cycle 0 → core_valid at cycle 1.
- If core_ready arrives at cycle k, cpu_ready is at cycle k+1: overhead is 2 cycles over the coprocessor latency.
- cpu_wait rises at cycle 1 and falls in the RESP cycle.
- Timeout: core_valid at cycle 1, forced cpu_ready at cycle TIMEOUT+1.
- Minimum spacing between two acceptances: 4 cycles (ISSUE, WAIT, RESP, COOL).
- Timer width $clog2(TIMEOUT+1); saturates and never wraps.

## Structure
- Shared package m_pkg holds:
  - OPCODE, FUNC7, OPCODE_CUSTOM, the func3 enum including ADDMOD/SUBMOD/MODQ, and the get_ir_* field extractors;
  - new function is_coproc_insn(logic [31:0]) returning the decode hit.
- The state enum is local to the module.
- No sub-module: single FSM plus timer and capture registers.

## Test plan
- MUL with rs1=7, rs2=6, core model with 3-cycle latency → core_valid at cycle 1, cpu_ready at cycle 4, cpu_wr=1, cpu_rd=42; core_rs1/rs2 stable throughout.
- DIVU with rs1=5, rs2=0, model returns 0xFFFFFFFF after 35 cycles → cpu_rd=0xFFFFFFFF, cpu_wr=1, cpu_wait high for cycles 1..35 inclusive.
- ADD (func7=0000000) with cpu_valid held 20 cycles → core_valid, cpu_wait and cpu_ready stay 0.
- Stalled core (core_ready never), TIMEOUT=48 → cpu_ready at cycle 49 with cpu_wr=0, cpu_rd=0, err_timeout=1 and staying 1.
- cpu_valid dropped at cycle 10 of a DIV, core_ready at cycle 35 → no cpu_ready; state in COOL at cycle 36 and IDLE at cycle 37; a next request is accepted normally.
- reset pulsed during WAIT → all outputs 0 immediately and err_timeout cleared; a fresh MUL with rs1=3, rs2=0xFFFFFFFF completes with cpu_rd=0xFFFFFFFD.
